// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the RV32I pipeline sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface pipeline_sequencer_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  run;
    logic                  fetch_complete;
    logic                  mem_complete;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_writes_rd;
    logic                  ex_is_load;
    logic                  jump_taken;

    logic                  fetch_enable;
    logic                  decode_enable;
    logic                  compute_enable;
    logic                  mem_enable;
    logic                  writeback_enable;
    logic                  flush;
    logic                  stall;
    logic [3:0]            stage_valid;
    logic [CNT_W-1:0]      retired_count;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        input  run, fetch_complete, mem_complete,
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_writes_rd, ex_is_load, jump_taken,
        output fetch_enable, decode_enable, compute_enable, mem_enable,
        output writeback_enable, flush, stall, stage_valid,
        output retired_count, stall_count
    );

    modport slave (
        output run, fetch_complete, mem_complete,
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_writes_rd, ex_is_load, jump_taken,
        input  fetch_enable, decode_enable, compute_enable, mem_enable,
        input  writeback_enable, flush, stall, stage_valid,
        input  retired_count, stall_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage pipeline sequencer: stage valid tracking, load-use bubbles, memory freeze, jump squash.
// Optional perf counters are built only when PIPE_PERF_COUNTERS_EN is defined.
module pipeline_sequencer #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input logic clock,
    input logic reset,
    pipeline_sequencer_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  v_id, v_ex, v_mem, v_wb;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  active;
    logic                  mem_stall;
    logic                  rs1_hit, rs2_hit;
    logic                  load_use;
    logic                  flush;
    logic                  advance;
    logic                  fetch_enable;
    logic                  decode_enable;

    assign ex_rd   = bus.ex_rd;
    assign active  = (state != IDLE) & ~reset;
    assign rs1_hit = bus.id_uses_rs1 & (bus.id_rs1 == ex_rd);
    assign rs2_hit = bus.id_uses_rs2 & (bus.id_rs2 == ex_rd);

    assign mem_stall = ~reset & v_mem & ~bus.mem_complete;
    assign load_use  = ~reset & v_ex & bus.ex_is_load & bus.ex_writes_rd &
                       (ex_rd != '0) & v_id & (rs1_hit | rs2_hit);

    // A pending memory access outranks the jump; the redirect waits for mem_complete.
    assign flush   = bus.jump_taken & ~mem_stall & active;
    assign advance = active & ~mem_stall & ~flush;

    assign fetch_enable  = flush | ((state == RUN) & ~reset & ~mem_stall & ~load_use);
    assign decode_enable = fetch_enable & ~flush & bus.fetch_complete;

    assign bus.fetch_enable     = fetch_enable;
    assign bus.decode_enable    = decode_enable;
    assign bus.compute_enable   = advance & ~load_use & v_id;
    assign bus.mem_enable       = advance & v_ex;
    assign bus.writeback_enable = ~reset & v_wb;
    assign bus.flush            = flush;
    assign bus.stall            = mem_stall | load_use;
    assign bus.stage_valid      = {v_wb, v_mem, v_ex, v_id};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.run) state_next = RUN;
            RUN:     if (!bus.run) state_next = DRAIN;
            DRAIN: begin
                if (bus.run)
                    state_next = RUN;
                else if ({v_wb, v_mem, v_ex, v_id} == 4'b0000)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            v_id  <= 1'b0;
            v_ex  <= 1'b0;
            v_mem <= 1'b0;
            v_wb  <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_stall) begin
                v_wb <= 1'b0;
            end else if (flush) begin
                // Everything younger than the jump in MEM is on the wrong path.
                v_wb  <= v_mem;
                v_mem <= 1'b0;
                v_ex  <= 1'b0;
                v_id  <= 1'b0;
            end else if (load_use) begin
                v_wb  <= v_mem;
                v_mem <= v_ex;
                v_ex  <= 1'b0;
            end else begin
                v_wb  <= v_mem;
                v_mem <= v_ex;
                v_ex  <= v_id;
                v_id  <= decode_enable;
            end
        end
    end

`ifdef PIPE_PERF_COUNTERS_EN
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] stall_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (bus.writeback_enable)
                retired_count <= retired_count + 1'b1;
            if (bus.stall)
                stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.retired_count = retired_count;
    assign bus.stall_count   = stall_count;
`else
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    assign bus.retired_count = CNT_ZERO;
    assign bus.stall_count   = CNT_ZERO;
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a cycle-by-cycle vector table for the
// hazard corner cases, then a scoreboarded hazard-free stream with random fetch gaps.
module tb_pipeline_sequencer;
    logic clock = 1'b0;
    logic reset;
    int   compared = 0;
    int   failed   = 0;

    always #5 clock = ~clock;

    pipeline_sequencer_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    pipeline_sequencer #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // exp_out = {fetch, decode, compute, mem, writeback, flush, stall};
    // exp_sv is stage_valid after the clock edge that ends the row.
    typedef struct {
        string      name;
        logic       rst;
        logic       run;
        logic       fc;
        logic       mc;
        logic       jmp;
        int         hz;
        logic [6:0] exp_out;
        logic [3:0] exp_sv;
    } vec_t;

    vec_t vecs[$];
    int   sb_queue[$];
    int   exp_retired = 0;
    int   exp_stalls  = 0;

    function automatic void addVec(string n, logic r, logic ru, logic f, logic m, logic j,
                                   int h, logic [6:0] o, logic [3:0] s);
        vec_t v;
        v.name = n; v.rst = r; v.run = ru; v.fc = f; v.mc = m; v.jmp = j;
        v.hz = h; v.exp_out = o; v.exp_sv = s;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset              = v.rst;
        bus.run            = v.run;
        bus.fetch_complete = v.fc;
        bus.mem_complete   = v.mc;
        bus.jump_taken     = v.jmp;
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_writes_rd = 1'b0; bus.ex_is_load = 1'b0;
        case (v.hz)
            1: begin
                bus.ex_rd = 5'd5; bus.ex_is_load = 1'b1; bus.ex_writes_rd = 1'b1;
                bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
            end
            2: begin
                bus.ex_rd = 5'd0; bus.ex_is_load = 1'b1; bus.ex_writes_rd = 1'b1;
                bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
            end
            3: begin
                bus.ex_rd = 5'd7; bus.ex_is_load = 1'b1; bus.ex_writes_rd = 1'b1;
                bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1;
                bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
            end
            4: begin
                bus.ex_rd = 5'd7; bus.ex_is_load = 1'b1; bus.ex_writes_rd = 1'b1;
                bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1;
                bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b0;
            end
            5: begin
                bus.ex_rd = 5'd9; bus.ex_is_load = 1'b0; bus.ex_writes_rd = 1'b1;
                bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [6:0] outVec();
        return {bus.fetch_enable, bus.decode_enable, bus.compute_enable, bus.mem_enable,
                bus.writeback_enable, bus.flush, bus.stall};
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus('{name: "init", rst: 1'b1, run: 1'b0, fc: 1'b0, mc: 1'b1, jmp: 1'b0,
                        hz: 0, exp_out: 7'd0, exp_sv: 4'd0});

        //      name                rst run fc  mc  jmp hz  fe,de,ce,me,wb,fl,st  stage_valid
        addVec("reset_hold",        1, 1, 1, 0, 1, 1, 7'b0000000, 4'b0000);
        addVec("idle_start",        0, 1, 1, 1, 0, 0, 7'b0000000, 4'b0000);
        addVec("fill1",             0, 1, 1, 1, 0, 0, 7'b1100000, 4'b0001);
        addVec("fill2",             0, 1, 1, 1, 0, 0, 7'b1110000, 4'b0011);
        addVec("fill3",             0, 1, 1, 1, 0, 0, 7'b1111000, 4'b0111);
        addVec("fill4",             0, 1, 1, 1, 0, 0, 7'b1111000, 4'b1111);
        addVec("first_wb",          0, 1, 1, 1, 0, 0, 7'b1111100, 4'b1111);
        addVec("lu_rs1",            0, 1, 1, 1, 0, 1, 7'b0001101, 4'b1101);
        addVec("lu_rs1_after",      0, 1, 1, 1, 0, 0, 7'b1110100, 4'b1011);
        addVec("lu_rs1_bubble",     0, 1, 1, 1, 0, 0, 7'b1111100, 4'b0111);
        addVec("lu_rs1_wb_gap",     0, 1, 1, 1, 0, 0, 7'b1111000, 4'b1111);
        addVec("x0_no_stall",       0, 1, 1, 1, 0, 2, 7'b1111100, 4'b1111);
        addVec("nonload_no_stall",  0, 1, 1, 1, 0, 5, 7'b1111100, 4'b1111);
        addVec("unused_rs2",        0, 1, 1, 1, 0, 4, 7'b1111100, 4'b1111);
        addVec("lu_rs2",            0, 1, 1, 1, 0, 3, 7'b0001101, 4'b1101);
        addVec("lu_rs2_after",      0, 1, 1, 1, 0, 0, 7'b1110100, 4'b1011);
        addVec("lu_rs2_bubble",     0, 1, 1, 1, 0, 0, 7'b1111100, 4'b0111);
        addVec("lu_rs2_wb_gap",     0, 1, 1, 1, 0, 0, 7'b1111000, 4'b1111);
        addVec("mem_stall1",        0, 1, 1, 0, 0, 0, 7'b0000101, 4'b0111);
        addVec("mem_stall2",        0, 1, 1, 0, 0, 0, 7'b0000001, 4'b0111);
        addVec("mem_stall3",        0, 1, 1, 0, 0, 0, 7'b0000001, 4'b0111);
        addVec("mem_done",          0, 1, 1, 1, 0, 0, 7'b1111000, 4'b1111);
        addVec("jump_flush",        0, 1, 1, 1, 1, 0, 7'b1000110, 4'b1000);
        addVec("jump_retire",       0, 1, 1, 1, 0, 0, 7'b1100100, 4'b0001);
        addVec("refill1",           0, 1, 1, 1, 0, 0, 7'b1110000, 4'b0011);
        addVec("refill2",           0, 1, 1, 1, 0, 0, 7'b1111000, 4'b0111);
        addVec("refill3",           0, 1, 1, 1, 0, 0, 7'b1111000, 4'b1111);
        addVec("stall_jump1",       0, 1, 1, 0, 1, 1, 7'b0000101, 4'b0111);
        addVec("stall_jump2",       0, 1, 1, 0, 1, 1, 7'b0000001, 4'b0111);
        addVec("jump_on_mem_done",  0, 1, 1, 1, 1, 1, 7'b1000011, 4'b1000);
        addVec("reset_mid_run",     1, 1, 1, 1, 0, 0, 7'b0000000, 4'b0000);
        addVec("restart_idle",      0, 1, 1, 1, 0, 0, 7'b0000000, 4'b0000);
        addVec("restart_fetch",     0, 1, 1, 1, 0, 0, 7'b1100000, 4'b0001);
        addVec("run_drop",          0, 0, 1, 1, 0, 0, 7'b1110000, 4'b0011);
        addVec("drain1",            0, 0, 1, 1, 0, 0, 7'b0011000, 4'b0110);
        addVec("drain2",            0, 0, 1, 1, 0, 0, 7'b0001000, 4'b1100);
        addVec("drain3",            0, 0, 1, 1, 0, 0, 7'b0000100, 4'b1000);
        addVec("drain4",            0, 0, 1, 1, 0, 0, 7'b0000100, 4'b0000);
        addVec("drain_empty",       0, 0, 1, 1, 0, 0, 7'b0000000, 4'b0000);
        addVec("idle_jump",         0, 0, 1, 1, 1, 0, 7'b0000000, 4'b0000);

        @(posedge clock); #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput({vecs[i].name, "_outs"}, {25'd0, outVec()}, {25'd0, vecs[i].exp_out});
            @(posedge clock); #1;
            if (vecs[i].rst) begin
                exp_retired = 0;
                exp_stalls  = 0;
            end else begin
`ifdef PIPE_PERF_COUNTERS_EN
                exp_retired += int'(vecs[i].exp_out[2]);
                exp_stalls  += int'(vecs[i].exp_out[0]);
`endif
            end
            checkOutput({vecs[i].name, "_valid"}, {28'd0, bus.stage_valid}, {28'd0, vecs[i].exp_sv});
            checkOutput({vecs[i].name, "_retired"}, bus.retired_count, exp_retired);
            checkOutput({vecs[i].name, "_stalls"}, bus.stall_count, exp_stalls);
        end

        // Hazard-free stream: each accepted fetch must retire exactly four cycles later.
        applyStimulus('{name: "stream_reset", rst: 1'b1, run: 1'b0, fc: 1'b0, mc: 1'b1, jmp: 1'b0,
                        hz: 0, exp_out: 7'd0, exp_sv: 4'd0});
        @(posedge clock); #1;
        reset   = 1'b0;
        bus.run = 1'b1;
        exp_retired = 0;
        @(posedge clock); #1;
        for (int cyc = 0; cyc < 64; cyc++) begin
            logic exp_wb;
            bus.fetch_complete = (cyc < 58) ? 1'($urandom_range(0, 1)) : 1'b0;
            #2;
            checkOutput("stream_fetch_en", {31'd0, bus.fetch_enable}, 32'd1);
            exp_wb = (sb_queue.size() > 0) && (sb_queue[0] == cyc);
            checkOutput("stream_wb", {31'd0, bus.writeback_enable}, {31'd0, exp_wb});
            if (exp_wb) begin
                void'(sb_queue.pop_front());
`ifdef PIPE_PERF_COUNTERS_EN
                exp_retired++;
`endif
            end
            if (bus.fetch_complete)
                sb_queue.push_back(cyc + 4);
            @(posedge clock); #1;
        end
        checkOutput("stream_drained", sb_queue.size(), 32'd0);
        checkOutput("stream_retired", bus.retired_count, exp_retired);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
